mcpu_core_exc_collect: RTL and testbench
========================================

Name: mcpu_core_exc_collect

Overview:
Exception/interrupt collection stage directly upstream of the core coprocessor block. Gathers per-lane decode fault codes, memory-port fault codes and fault addresses, plus synchronized external interrupt lines. Produces the single-cycle `exception` strobe and the latched `combined_ec0..3` / `mem_vaddr0..1` values that the coprocessor captures into its cause and address registers. Stalls issue during the post-exception pipeline flush.

Parameters:
NUM_IRQ, 8, number of external interrupt lines.
FLUSH_CYCLES, 3, cycles `exc_busy` stays high after the strobe cycle; legal range 1..15.

Ports:
clkrst_core_clk  in  1  core clock
clkrst_core_rst_n  in  1  asynchronous active-low reset
pc_ready_in  in  1  execute packet advances this cycle
pkt_valid  in  1  execute packet is real (not a bubble)
lane_ec0..lane_ec3  in  5 each  decode-detected code per lane; 0 = none
mem_ec0, mem_ec1  in  5 each  memory-port fault code; port k belongs to lane k; 0 = none
mem_vaddr_in0, mem_vaddr_in1  in  32 each  faulting/accessed virtual address per port
ext_irq  in  NUM_IRQ  asynchronous external interrupt lines
irq_clear  in  NUM_IRQ  write-1-to-clear pending bits
interrupts_enabled  in  1  global enable from coprocessor
exception  out  1  one-cycle exception strobe to coprocessor
combined_ec0..combined_ec3  out  5 each  latched per-lane cause codes
mem_vaddr0, mem_vaddr1  out  32 each  latched fault addresses
irq_pending  out  NUM_IRQ  sticky pending bits
exc_busy  out  1  stall issue; high from the strobe cycle through the flush

Behaviour:
- Reset (async, active-low): all outputs 0, state IDLE, synchronizers and pending cleared, counter 0.
- IRQ path: each `ext_irq` bit passes through a 2-flop synchronizer plus one edge-detect flop.
  - A rising edge sets `irq_pending[i]`.
  - `irq_clear[i]` clears it.
  - A new edge and a clear in the same cycle: set wins.
  - Pending bits are never cleared by taking an interrupt.
  - Edge-to-pending latency: 3 cycles.
- Per-lane code, computed combinationally:
  - Lanes 0/1: `lane_ec` if nonzero, else `mem_ec`.
  - Lanes 2/3: `lane_ec` only.
- Interrupt request: `irq_req` = |irq_pending & interrupts_enabled.
- Trigger in cycle N requires all of: state IDLE, pc_ready_in, pkt_valid, and (any lane code nonzero OR irq_req).
- When triggered:
  - Latch combined_ec0..3 from the per-lane codes.
  - If all lane codes are 0, latch combined_ec0 = EC_INTERRUPT and lanes 1..3 = 0. Synchronous faults always win over interrupts.
  - Latch mem_vaddr0/1 from the inputs.
  - All latched values appear in cycle N+1 and are held until the next trigger.
- State machine:
  - IDLE: on trigger -> FIRE.
  - FIRE, one cycle: exception=1, exc_busy=1, counter loaded with FLUSH_CYCLES-1 -> FLUSH.
  - FLUSH: exc_busy=1, exception=0. Counter decrements each cycle; when the counter is 0, the next state is IDLE.
- Triggers are ignored in FIRE and FLUSH. Faults during the flush are squashed packets and are dropped, not queued.
- Timing: exc_busy is high for exactly 1+FLUSH_CYCLES cycles; the first trigger is accepted again in the cycle after exc_busy falls.
- pkt_valid=0 or pc_ready_in=0: no trigger, regardless of codes or IRQs.
- Reset asserted mid-FIRE/FLUSH: immediate return to IDLE, outputs 0.

Decomposition:
- Shared package/header (mcpu_core_exc_codes.vh, alongside the coproc op codes):
  - EC_NONE=0 and EC_INTERRUPT plus the other 5-bit cause codes.
  - State encodings IDLE/FIRE/FLUSH.
- One natural sub-module: mcpu_core_irq_sync. Holds the per-line 2-flop sync, edge detect and sticky pending with W1C; NUM_IRQ wide.

Test Plan:
- Reset during FLUSH with combined_ec0=6 latched -> all outputs 0 immediately; next trigger still works.
- lane_ec2=5, pkt_valid=1, pc_ready_in=1 at cycle N -> exception=1 only in N+1; combined_ec=0,0,5,0; exc_busy high N+1..N+4 (FLUSH_CYCLES=3).
- mem_ec0=9 with lane_ec0=0, and mem_ec1=9 with lane_ec1=4, mem_vaddr_in0=0x0000_1234 -> combined_ec0=9, combined_ec1=4, mem_vaddr0=0x0000_1234.
- ext_irq[3] rises, interrupts_enabled=1, idle valid packet, no faults -> irq_pending[3]=1 after 3 cycles; next advancing packet gives exception with combined_ec0=EC_INTERRUPT; pending stays 1 until irq_clear[3].
- IRQ pending plus lane_ec1=7 in the same cycle -> combined_ec=0,7,0,0 (no interrupt code); irq_pending still set.
- Second fault presented during FLUSH -> no second strobe, latched codes unchanged. Same fault held until IDLE -> strobe fires the cycle after exc_busy falls. irq edge and irq_clear in the same cycle -> pending=1.

Source files
------------

// File: rtl/mcpu_core_exc_collect_pkg.sv
// Shared definitions for the exception collection stage.
//   - 5-bit cause codes. EC_NONE means "no fault on this lane".
//   - Collector FSM state encoding.
//   - lane_code(): merge rule for lanes that also own a memory port.
package mcpu_core_exc_collect_pkg;

    localparam int EC_W = 5;

    localparam logic [EC_W-1:0] EC_NONE      = 5'd0;
    localparam logic [EC_W-1:0] EC_ADEL      = 5'd4;
    localparam logic [EC_W-1:0] EC_ADES      = 5'd5;
    localparam logic [EC_W-1:0] EC_IBE       = 5'd6;
    localparam logic [EC_W-1:0] EC_DBE       = 5'd7;
    localparam logic [EC_W-1:0] EC_SYS       = 5'd8;
    localparam logic [EC_W-1:0] EC_BP        = 5'd9;
    localparam logic [EC_W-1:0] EC_RI        = 5'd10;
    localparam logic [EC_W-1:0] EC_CPU       = 5'd11;
    localparam logic [EC_W-1:0] EC_OV        = 5'd12;
    localparam logic [EC_W-1:0] EC_INTERRUPT = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_FLUSH = 2'd2
    } exc_state_e;

    // A decode fault is older in program order than the memory access of
    // the same lane, so it takes precedence over the memory-port code.
    function automatic logic [EC_W-1:0] lane_code(input logic [EC_W-1:0] lane_ec,
                                                  input logic [EC_W-1:0] mem_ec);
        return (lane_ec != EC_NONE) ? lane_ec : mem_ec;
    endfunction

endpackage

// File: rtl/mcpu_core_irq_sync.sv
// External interrupt front end.
// Each line: 2-flop synchronizer, one edge-detect flop, sticky pending bit.
// A rising edge sets pending; irq_clear (W1C) clears it; set beats clear.
// Ports:
//   clkrst_core_clk, clkrst_core_rst_n : clock, async active-low reset
//   ext_irq     : asynchronous interrupt lines
//   irq_clear   : write-1-to-clear pending bits
//   irq_pending : sticky pending bits (edge-to-pending latency 3 cycles)
module mcpu_core_irq_sync #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clkrst_core_clk,
    input  logic               clkrst_core_rst_n,
    input  logic [NUM_IRQ-1:0] ext_irq,
    input  logic [NUM_IRQ-1:0] irq_clear,
    output logic [NUM_IRQ-1:0] irq_pending
);

    logic [NUM_IRQ-1:0] sync_q1;
    logic [NUM_IRQ-1:0] sync_q2;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] rise;

    assign rise = sync_q2 & ~edge_q;

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            edge_q      <= '0;
            irq_pending <= '0;
        end else begin
            sync_q1     <= ext_irq;
            sync_q2     <= sync_q1;
            edge_q      <= sync_q2;
            irq_pending <= (irq_pending & ~irq_clear) | rise;
        end
    end

endmodule

// File: rtl/mcpu_core_exc_collect.sv
// Exception/interrupt collection stage feeding the coprocessor.
// Merges per-lane decode and memory-port fault codes with pending external
// interrupts, fires a one-cycle exception strobe, latches the cause codes
// and fault addresses, and holds exc_busy through the post-exception flush.
// Ports:
//   clkrst_core_clk, clkrst_core_rst_n : clock, async active-low reset
//   pc_ready_in, pkt_valid   : execute packet advances / is real
//   lane_ec0..3              : decode fault code per lane (0 = none)
//   mem_ec0..1               : memory-port fault code, port k = lane k
//   mem_vaddr_in0..1         : virtual address per memory port
//   ext_irq, irq_clear       : interrupt lines and W1C for pending bits
//   interrupts_enabled       : global interrupt enable
//   exception                : one-cycle strobe to coprocessor
//   combined_ec0..3          : latched cause codes
//   mem_vaddr0..1            : latched fault addresses
//   irq_pending              : sticky pending bits
//   exc_busy                 : issue stall, strobe cycle through flush
module mcpu_core_exc_collect
    import mcpu_core_exc_collect_pkg::*;
#(
    parameter int NUM_IRQ      = 8,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic               clkrst_core_clk,
    input  logic               clkrst_core_rst_n,
    input  logic               pc_ready_in,
    input  logic               pkt_valid,
    input  logic [4:0]         lane_ec0,
    input  logic [4:0]         lane_ec1,
    input  logic [4:0]         lane_ec2,
    input  logic [4:0]         lane_ec3,
    input  logic [4:0]         mem_ec0,
    input  logic [4:0]         mem_ec1,
    input  logic [31:0]        mem_vaddr_in0,
    input  logic [31:0]        mem_vaddr_in1,
    input  logic [NUM_IRQ-1:0] ext_irq,
    input  logic [NUM_IRQ-1:0] irq_clear,
    input  logic               interrupts_enabled,
    output logic               exception,
    output logic [4:0]         combined_ec0,
    output logic [4:0]         combined_ec1,
    output logic [4:0]         combined_ec2,
    output logic [4:0]         combined_ec3,
    output logic [31:0]        mem_vaddr0,
    output logic [31:0]        mem_vaddr1,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               exc_busy
);

    // Counter holds remaining flush cycles after the first FLUSH cycle.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [4:0] code0, code1, code2, code3;
    logic       any_fault;
    logic       irq_req;
    logic       take;

    mcpu_core_irq_sync #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_sync (
        .clkrst_core_clk   (clkrst_core_clk),
        .clkrst_core_rst_n (clkrst_core_rst_n),
        .ext_irq           (ext_irq),
        .irq_clear         (irq_clear),
        .irq_pending       (irq_pending)
    );

    // Only lanes 0/1 own a memory port.
    assign code0     = lane_code(lane_ec0, mem_ec0);
    assign code1     = lane_code(lane_ec1, mem_ec1);
    assign code2     = lane_ec2;
    assign code3     = lane_ec3;
    assign any_fault = |{code0, code1, code2, code3};
    assign irq_req   = (|irq_pending) & interrupts_enabled;
    assign take      = (state_q == ST_IDLE) & pc_ready_in & pkt_valid & (any_fault | irq_req);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exception = 1'b0;
        exc_busy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) state_d = ST_FIRE;
            end
            ST_FIRE: begin
                exception = 1'b1;
                exc_busy  = 1'b1;
                cnt_d     = FLUSH_LOAD;
                state_d   = ST_FLUSH;
            end
            ST_FLUSH: begin
                exc_busy = 1'b1;
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Cause/address capture. Synchronous faults always win; the interrupt
    // code is only reported when no lane carries a fault.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            combined_ec0 <= EC_NONE;
            combined_ec1 <= EC_NONE;
            combined_ec2 <= EC_NONE;
            combined_ec3 <= EC_NONE;
            mem_vaddr0   <= '0;
            mem_vaddr1   <= '0;
        end else if (take) begin
            combined_ec0 <= any_fault ? code0 : EC_INTERRUPT;
            combined_ec1 <= code1;
            combined_ec2 <= code2;
            combined_ec3 <= code3;
            mem_vaddr0   <= mem_vaddr_in0;
            mem_vaddr1   <= mem_vaddr_in1;
        end
    end

endmodule

// File: tb/tb_mcpu_core_exc_collect.sv
module tb_mcpu_core_exc_collect;
    import mcpu_core_exc_collect_pkg::*;

    localparam int N = 8;
    localparam int F = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pc_ready_in, pkt_valid;
    logic [4:0]   lane_ec0, lane_ec1, lane_ec2, lane_ec3, mem_ec0, mem_ec1;
    logic [31:0]  mem_vaddr_in0, mem_vaddr_in1;
    logic [N-1:0] ext_irq, irq_clear;
    logic         interrupts_enabled;
    logic         exception, exc_busy;
    logic [4:0]   combined_ec0, combined_ec1, combined_ec2, combined_ec3;
    logic [31:0]  mem_vaddr0, mem_vaddr1;
    logic [N-1:0] irq_pending;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: remaining busy cycles, latched values,
    // pending bits and the history of sampled interrupt lines.
    int           m_busy;
    logic [4:0]   m_ec [4];
    logic [31:0]  m_va0, m_va1;
    logic [N-1:0] m_pend;
    logic [N-1:0] ext_hist [$];

    mcpu_core_exc_collect #(.NUM_IRQ(N), .FLUSH_CYCLES(F)) dut (
        .clkrst_core_clk    (clk),
        .clkrst_core_rst_n  (rst_n),
        .pc_ready_in        (pc_ready_in),
        .pkt_valid          (pkt_valid),
        .lane_ec0           (lane_ec0),
        .lane_ec1           (lane_ec1),
        .lane_ec2           (lane_ec2),
        .lane_ec3           (lane_ec3),
        .mem_ec0            (mem_ec0),
        .mem_ec1            (mem_ec1),
        .mem_vaddr_in0      (mem_vaddr_in0),
        .mem_vaddr_in1      (mem_vaddr_in1),
        .ext_irq            (ext_irq),
        .irq_clear          (irq_clear),
        .interrupts_enabled (interrupts_enabled),
        .exception          (exception),
        .combined_ec0       (combined_ec0),
        .combined_ec1       (combined_ec1),
        .combined_ec2       (combined_ec2),
        .combined_ec3       (combined_ec3),
        .mem_vaddr0         (mem_vaddr0),
        .mem_vaddr1         (mem_vaddr1),
        .irq_pending        (irq_pending),
        .exc_busy           (exc_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 0;
        for (int i = 0; i < 4; i++) m_ec[i] = 5'd0;
        m_va0  = '0;
        m_va1  = '0;
        m_pend = '0;
        ext_hist = {};
        repeat (3) ext_hist.push_back('0);
    endtask

    task automatic cmp_model();
        chk("exception", 32'(exception), 32'(m_busy == F + 1));
        chk("exc_busy", 32'(exc_busy), 32'(m_busy > 0));
        chk("combined_ec0", 32'(combined_ec0), 32'(m_ec[0]));
        chk("combined_ec1", 32'(combined_ec1), 32'(m_ec[1]));
        chk("combined_ec2", 32'(combined_ec2), 32'(m_ec[2]));
        chk("combined_ec3", 32'(combined_ec3), 32'(m_ec[3]));
        chk("mem_vaddr0", mem_vaddr0, m_va0);
        chk("mem_vaddr1", mem_vaddr1, m_va1);
        chk("irq_pending", 32'(irq_pending), 32'(m_pend));
    endtask

    always @(negedge clk) if (rst_n === 1'b1) cmp_model();

    // One clock: evaluate the rules on the inputs presented this cycle,
    // advance the model at the edge, return on the following negedge.
    task automatic cycle();
        logic [4:0]   c [4];
        logic         trig;
        logic [N-1:0] rise;
        c[0] = (lane_ec0 != 0) ? lane_ec0 : mem_ec0;
        c[1] = (lane_ec1 != 0) ? lane_ec1 : mem_ec1;
        c[2] = lane_ec2;
        c[3] = lane_ec3;
        trig = (m_busy == 0) && pc_ready_in && pkt_valid &&
               ((c[0] | c[1] | c[2] | c[3]) != 0 || ((m_pend != 0) && interrupts_enabled));
        @(posedge clk);
        ext_hist.push_back(ext_irq);
        rise = ext_hist[1] & ~ext_hist[0];   // sampled 2 edges ago high, 3 edges ago low
        void'(ext_hist.pop_front());
        m_pend = (m_pend & ~irq_clear) | rise;
        if (trig) begin
            m_busy = F + 1;
            if ((c[0] | c[1] | c[2] | c[3]) == 0) begin
                m_ec[0] = EC_INTERRUPT;
                for (int i = 1; i < 4; i++) m_ec[i] = 5'd0;
            end else begin
                for (int i = 0; i < 4; i++) m_ec[i] = c[i];
            end
            m_va0 = mem_vaddr_in0;
            m_va1 = mem_vaddr_in1;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        pkt_valid = 1'b0;
        lane_ec0 = 0; lane_ec1 = 0; lane_ec2 = 0; lane_ec3 = 0;
        mem_ec0 = 0; mem_ec1 = 0;
        irq_clear = '0;
    endtask

    task automatic drain();
        int guard = 0;
        quiet();
        while ((m_busy > 0 || exc_busy) && guard < 40) begin
            cycle();
            guard++;
        end
        chk("drain_timeout", 32'(guard < 40), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        pc_ready_in = 1'b0;
        interrupts_enabled = 1'b0;
        ext_irq = '0;
        mem_vaddr_in0 = '0;
        mem_vaddr_in1 = '0;
        quiet();
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_exception", 32'(exception), 0);
        chk("rst_busy", 32'(exc_busy), 0);
        chk("rst_ec", 32'({combined_ec0, combined_ec1, combined_ec2, combined_ec3}), 0);
        chk("rst_vaddr", mem_vaddr0 | mem_vaddr1, 0);
        chk("rst_pending", 32'(irq_pending), 0);
        rst_n = 1'b1;

        // Single lane-2 fault: strobe in N+1 only, busy N+1..N+4.
        pc_ready_in = 1'b1; pkt_valid = 1'b1; lane_ec2 = 5'd5;
        cycle();
        chk("lane2_strobe", 32'(exception), 1);
        chk("lane2_codes", 32'({combined_ec0, combined_ec1, combined_ec2, combined_ec3}),
            32'({5'd0, 5'd0, 5'd5, 5'd0}));
        quiet();
        for (int i = 0; i < F; i++) begin
            cycle();
            chk("lane2_flush_busy", 32'(exc_busy), 1);
            chk("lane2_flush_nostrobe", 32'(exception), 0);
        end
        cycle();
        chk("lane2_busy_fall", 32'(exc_busy), 0);

        // Memory-port merge.
        pkt_valid = 1'b1; mem_ec0 = 5'd9; lane_ec1 = 5'd4; mem_ec1 = 5'd9;
        mem_vaddr_in0 = 32'h0000_1234; mem_vaddr_in1 = 32'hdead_beef;
        cycle();
        chk("mem_ec0", 32'(combined_ec0), 9);
        chk("mem_ec1_lane_wins", 32'(combined_ec1), 4);
        chk("mem_vaddr0", mem_vaddr0, 32'h0000_1234);
        drain();

        // IRQ 3: pending after 3 edges, interrupt code, stays pending.
        interrupts_enabled = 1'b1;
        ext_irq[3] = 1'b1;
        cycle(); cycle();
        chk("irq3_not_yet", 32'(irq_pending[3]), 0);
        cycle();
        chk("irq3_pending", 32'(irq_pending[3]), 1);
        pkt_valid = 1'b1;
        cycle();
        chk("irq3_strobe", 32'(exception), 1);
        chk("irq3_code", 32'(combined_ec0), 32'(EC_INTERRUPT));
        drain();
        chk("irq3_sticky", 32'(irq_pending[3]), 1);
        irq_clear[3] = 1'b1;
        cycle();
        irq_clear = '0;
        chk("irq3_cleared", 32'(irq_pending[3]), 0);

        // Edge and clear on the same edge: set wins.
        interrupts_enabled = 1'b0;
        ext_irq[5] = 1'b1;
        cycle(); cycle();
        irq_clear[5] = 1'b1;
        cycle();
        irq_clear = '0;
        chk("irq5_set_wins", 32'(irq_pending[5]), 1);

        // Fault and pending IRQ together: fault code only.
        interrupts_enabled = 1'b1;
        pkt_valid = 1'b1; lane_ec1 = 5'd7;
        cycle();
        chk("fault_over_irq", 32'({combined_ec0, combined_ec1, combined_ec2, combined_ec3}),
            32'({5'd0, 5'd7, 5'd0, 5'd0}));
        chk("fault_irq_still_pending", 32'(irq_pending[5]), 1);
        drain();
        irq_clear = '1;
        cycle();
        interrupts_enabled = 1'b0;

        // Fault held through flush: dropped, then accepted after busy falls.
        quiet();
        pkt_valid = 1'b1; lane_ec0 = 5'd3;
        cycle();
        lane_ec0 = 5'd0; lane_ec2 = 5'd8;
        for (int i = 0; i < F; i++) begin
            cycle();
            chk("flush_no_second", 32'(exception), 0);
            chk("flush_codes_held", 32'(combined_ec0), 3);
        end
        cycle();
        chk("held_busy_low", 32'(exc_busy), 0);
        cycle();
        chk("held_strobe", 32'(exception), 1);
        chk("held_code", 32'({combined_ec0, combined_ec2}), 32'({5'd0, 5'd8}));
        drain();

        // Reset during FLUSH.
        pkt_valid = 1'b1; lane_ec0 = 5'd6;
        cycle();
        quiet();
        cycle();
        chk("pre_reset_ec0", 32'(combined_ec0), 6);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(exc_busy), 0);
        chk("midrst_exception", 32'(exception), 0);
        chk("midrst_ec0", 32'(combined_ec0), 0);
        chk("midrst_pending", 32'(irq_pending), 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pkt_valid = 1'b1; lane_ec3 = 5'd2;
        cycle();
        chk("post_rst_strobe", 32'(exception), 1);
        chk("post_rst_ec3", 32'(combined_ec3), 2);
        drain();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            pc_ready_in        = ($urandom_range(0, 4) != 0);
            pkt_valid          = ($urandom_range(0, 4) != 0);
            interrupts_enabled = ($urandom_range(0, 3) != 0);
            lane_ec0 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            lane_ec1 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            lane_ec2 = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'd0;
            lane_ec3 = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'd0;
            mem_ec0  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            mem_ec1  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            mem_vaddr_in0 = $urandom;
            mem_vaddr_in1 = $urandom;
            if ($urandom_range(0, 5) == 0) ext_irq = ext_irq ^ N'($urandom);
            irq_clear = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
